// File: rtl/fp_to_bcd_if.sv
// Request/result bundle between a display driver and the fp_to_bcd converter.
// Request: d_in is taken on a rising edge where valid_in && ready_out; results strobe valid_out for one cycle.
interface fp_to_bcd_if #(
  parameter int FRAC_DIGITS = 4
);
  logic [31:0]              d_in;
  logic                     valid_in;
  logic                     ready_out;
  logic                     valid_out;
  logic                     sign_out;
  logic [15:0]              int_bcd_out;
  logic [4*FRAC_DIGITS-1:0] frac_bcd_out;

  modport master (
    output d_in, valid_in,
    input  ready_out, valid_out, sign_out, int_bcd_out, frac_bcd_out
  );

  modport slave (
    input  d_in, valid_in,
    output ready_out, valid_out, sign_out, int_bcd_out, frac_bcd_out
  );
endinterface

// File: rtl/fp_to_bcd.sv
// Q12.20 signed value to sign + BCD: double-dabble on the integer part,
// repeated multiply-by-10 on the fraction (truncated). One request at a time.
module fp_to_bcd #(
  parameter int FRAC_DIGITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  fp_to_bcd_if.slave  bus,
  output logic [1:0]  state_dbg
);
  localparam int FW = 4 * FRAC_DIGITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INT  = 2'd1;
  localparam logic [1:0] FRAC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [11:0]   int_reg;
  logic [19:0]   frac_reg;
  logic [15:0]   bcd;
  logic [FW-1:0] frac_sr;
  logic          sign_reg;

  logic          valid_q;
  logic          sign_q;
  logic [15:0]   int_bcd_q;
  logic [FW-1:0] frac_bcd_q;

  logic [31:0]   mag;
  logic [15:0]   bcd_adj;
  logic [23:0]   prod;
  logic [FW+3:0] frac_shift;

  // 0x8000_0000 negates to itself; read as unsigned it is exactly 2048.0.
  always_comb begin
    mag = bus.d_in[31] ? (~bus.d_in + 32'd1) : bus.d_in;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < 4; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // Top nibble of frac*10 is the next decimal digit; it enters at the LSB end.
  always_comb begin
    prod       = {4'd0, frac_reg} * 24'd10;
    frac_shift = {frac_sr, prod[23:20]};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      int_reg    <= 12'd0;
      frac_reg   <= 20'd0;
      bcd        <= 16'd0;
      frac_sr    <= '0;
      sign_reg   <= 1'b0;
      valid_q    <= 1'b0;
      sign_q     <= 1'b0;
      int_bcd_q  <= 16'd0;
      frac_bcd_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            sign_reg <= bus.d_in[31];
            int_reg  <= mag[31:20];
            frac_reg <= mag[19:0];
            bcd      <= 16'd0;
            frac_sr  <= '0;
            cnt      <= 4'd12;
            state    <= INT;
          end
        end
        INT: begin
          bcd     <= {bcd_adj[14:0], int_reg[11]};
          int_reg <= {int_reg[10:0], 1'b0};
          if (cnt == 4'd1) begin
            cnt   <= 4'(FRAC_DIGITS);
            state <= FRAC;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        FRAC: begin
          frac_sr  <= frac_shift[FW-1:0];
          frac_reg <= prod[19:0];
          cnt      <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE: begin
          sign_q     <= sign_reg;
          int_bcd_q  <= bcd;
          frac_bcd_q <= frac_sr;
          valid_q    <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_out    = (state == IDLE);
  assign bus.valid_out    = valid_q;
  assign bus.sign_out     = sign_q;
  assign bus.int_bcd_out  = int_bcd_q;
  assign bus.frac_bcd_out = frac_bcd_q;
  assign state_dbg        = state;
endmodule

// File: tb/tb_fp_to_bcd.sv
// Scoreboard bench for fp_to_bcd: default build (4 fraction digits) plus a
// 6-digit build; expected values come from an arithmetic reference model.
module tb_fp_to_bcd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;

  logic [32:0] exp_q[$];
  int          acc_q[$];

  logic [1:0] state_dbg;
  logic [1:0] state_dbg6;

  fp_to_bcd_if #(.FRAC_DIGITS(4)) bus ();
  fp_to_bcd_if #(.FRAC_DIGITS(6)) bus6 ();

  fp_to_bcd #(.FRAC_DIGITS(4)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus.slave), .state_dbg(state_dbg)
  );
  fp_to_bcd #(.FRAC_DIGITS(6)) dut6 (
    .clk_in(clk), .rst_in(rst), .bus(bus6.slave), .state_dbg(state_dbg6)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference: {sign, int_bcd[15:0], frac_bcd[23:0]}, fraction right-aligned in f digits.
  function automatic logic [40:0] model(input logic [31:0] d, input int f);
    logic [31:0] m;
    logic [63:0] ip;
    logic [63:0] fs;
    logic [63:0] p10;
    logic [15:0] ib;
    logic [23:0] fb;
    m  = d[31] ? (~d + 32'd1) : d;
    ip = {52'd0, m[31:20]};
    ib = '0;
    for (int k = 0; k < 4; k++) begin
      ib[4*k +: 4] = 4'(ip % 64'd10);
      ip = ip / 64'd10;
    end
    p10 = 64'd1;
    for (int k = 0; k < f; k++) p10 = p10 * 64'd10;
    fs = ({44'd0, m[19:0]} * p10) >> 20;
    fb = '0;
    for (int k = 0; k < f; k++) begin
      fb[4*k +: 4] = 4'(fs % 64'd10);
      fs = fs / 64'd10;
    end
    return {d[31], ib, fb};
  endfunction

  function automatic logic [32:0] exp4(input logic [31:0] d);
    logic [40:0] r;
    r = model(d, 4);
    return {r[40], r[39:24], r[15:0]};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.valid_out) begin
      vcount++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        int a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("sign", {63'd0, bus.sign_out}, {63'd0, e[32]});
        check("int_bcd", {48'd0, bus.int_bcd_out}, {48'd0, e[31:16]});
        check("frac_bcd", {48'd0, bus.frac_bcd_out}, {48'd0, e[15:0]});
        check("latency", 64'(cyc - a), 64'd17);
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", {63'd0, bus.ready_out}, 64'd1);
  endtask

  task automatic send(input logic [31:0] d);
    wait_ready();
    bus.d_in     = d;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(exp4(d));
    acc_q.push_back(cyc);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.ready_out) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [40:0] e6;
    int a6;
    int cnt;
    int vbefore;

    bus.d_in      = '0;
    bus.valid_in  = 1'b0;
    bus6.d_in     = '0;
    bus6.valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_ready", {63'd0, bus.ready_out}, 64'd1);
    check("rst_valid", {63'd0, bus.valid_out}, 64'd0);
    check("rst_sign", {63'd0, bus.sign_out}, 64'd0);
    check("rst_int", {48'd0, bus.int_bcd_out}, 64'd0);
    check("rst_frac", {48'd0, bus.frac_bcd_out}, 64'd0);

    // six-digit build, run alongside
    bus6.d_in     = 32'h0032_43F6;
    bus6.valid_in = 1'b1;
    @(posedge clk);
    #1;
    a6 = cyc;
    bus6.valid_in = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (!bus6.valid_out && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    e6 = model(32'h0032_43F6, 6);
    check("f6_latency", 64'(cyc - a6), 64'd19);
    check("f6_sign", {63'd0, bus6.sign_out}, {63'd0, e6[40]});
    check("f6_int", {48'd0, bus6.int_bcd_out}, {48'd0, e6[39:24]});
    check("f6_frac", {40'd0, bus6.frac_bcd_out}, {40'd0, e6[23:0]});

    // directed values, including boundaries
    send(32'h0018_0000);
    send(32'hFFFC_0000);
    send(32'h8000_0000);
    send(32'h7FFF_FFFF);
    send(32'h0000_0001);
    send(32'h0000_0000);
    send(32'hFFFF_FFFF);

    // random values with random idle gaps
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send($urandom);
    end
    wait_idle();

    // valid_in held high while busy: second value waits for IDLE
    @(negedge clk);
    bus.d_in     = 32'h0018_0000;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(exp4(32'h0018_0000));
    acc_q.push_back(cyc);
    bus.d_in = 32'h0064_0000;
    cnt = 0;
    @(negedge clk);
    while (!bus.ready_out && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_len", 64'(cnt), 64'd17);
    @(posedge clk);
    #1;
    exp_q.push_back(exp4(32'h0064_0000));
    acc_q.push_back(cyc);
    bus.valid_in = 1'b0;
    wait_idle();

    // reset 5 cycles into a conversion
    @(negedge clk);
    bus.d_in     = 32'h0018_0000;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1 bus.valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {63'd0, bus.ready_out}, 64'd1);
    check("abort_valid", {63'd0, bus.valid_out}, 64'd0);
    check("abort_sign", {63'd0, bus.sign_out}, 64'd0);
    check("abort_int", {48'd0, bus.int_bcd_out}, 64'd0);
    check("abort_frac", {48'd0, bus.frac_bcd_out}, 64'd0);
    vbefore = vcount;
    repeat (25) @(negedge clk);
    check("abort_no_valid", 64'(vcount - vbefore), 64'd0);
    send(32'h0018_0000);
    wait_idle();

    // reset and request together: reset wins
    @(negedge clk);
    rst          = 1'b1;
    bus.d_in     = 32'h0018_0000;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check("rst_wins_ready", {63'd0, bus.ready_out}, 64'd1);
    vbefore = vcount;
    repeat (20) @(negedge clk);
    check("rst_wins_no_valid", 64'(vcount - vbefore), 64'd0);

    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
